multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS control unit that sequences the shared datapath (single memory, single ALU, IR, A/B/ALUOut/MDR registers) one instruction at a time. It replaces single-cycle opcode decoding with a state machine that reads opcode/funct from the instruction register and drives per-cycle mux selects, register enables and memory strobes. Memory accesses use a ready handshake so variable-latency memory stalls the sequence.

## Interface
- No parameters; opcodes, states and ALU op codes come from the shared package.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if branch condition holds
- branch_ne  out  1  condition is Zero=0 (bne), else Zero=1 (beq)
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memread / memwrite  out  1 each  memory strobes
- irwrite  out  1  IR load
- memtoreg  out  1  write data: 0=ALUOut, 1=MDR
- regdst  out  1  write reg: 0=rt, 1=rd
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0=PC, 1=reg A
- alusrcb  out  2  ALU B: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 slt
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reg A (jr)
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse on undecodable opcode

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP, JR, TRAP.
- Unlisted outputs are 0 in every state.
- RESET: all 0; next FETCH.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite=pcwrite=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode: 0 with funct 8 -> JR; 0 otherwise -> REXEC; 35/43 -> MEMADR; 4/5 -> BRANCH; 8/10 -> IEXEC; 2 -> JUMP; else TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next MEMRD (35) or MEMWR (43).
- MEMRD: memread=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Next FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready. instr_done=mem_ready. Then FETCH.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Next RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next FETCH.
- IEXEC: alusrca=1, alusrcb=10, aluop=00 (addi) or 11 (slti). Next IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, branch_ne=(opcode==5), instr_done=1. Next FETCH.
- JUMP: pcwrite=1, pcsource=10, instr_done=1. JR: pcwrite=1, pcsource=11, instr_done=1. Both go to FETCH.
- TRAP: illegal=1, instr_done=1, no writes. Next FETCH; the PC already advanced in FETCH.

## Timing
- State register updates on rising clk. Outputs are decoded combinationally from state; irwrite, pcwrite (FETCH) and instr_done (MEMWR) are also qualified by mem_ready.
- reset_n low asynchronously forces RESET, so every output is 0. The first FETCH is the cycle after the first rising edge with reset_n high.
- Latency with zero-wait memory (mem_ready=1 throughout): beq/bne/j/jr/illegal 3 cycles, R-type/addi/slti/sw 4, lw 5. Each memory stall cycle adds 1.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- memread/memwrite stay asserted and the address stays stable for the whole stall.
- Reset mid-instruction aborts it with no further writes; an in-flight memwrite drops immediately.

## Structure
- Package mips_ctrl_pkg holds opcode constants (R=0, J=2, BEQ=4, BNE=5, ADDI=8, SLTI=10, LW=35, SW=43), FUNCT_JR=8, the state enum, and the aluop/alusrcb/pcsource encodings. The datapath shares these.
- Single module, no sub-module. Use one sequential block for the state register and one combinational block each for next-state and outputs.

## Test plan
- Reset: hold reset_n low mid-MEMWR -> memwrite drops immediately and all outputs are 0. Release -> RESET, then FETCH with memread=1 and alusrcb=01.
- add (opcode 0, funct 32), mem_ready=1 -> FETCH, DECODE, REXEC (aluop=10), RWB (regwrite=1, regdst=1, instr_done=1). Next FETCH on cycle 5.
- lw (35) with mem_ready low for 2 cycles in MEMRD -> memread=1, iord=1 held 3 cycles. MEMWB has memtoreg=1, regwrite=1. 7 cycles total.
- bne (5) -> BRANCH with pcwritecond=1, branch_ne=1, pcsource=01, aluop=01. beq (4) gives branch_ne=0.
- slti (10) -> IEXEC aluop=11. j (2) -> pcsource=10. jr (0/funct 8) -> pcsource=11 with no regwrite.
- opcode 63 -> TRAP: illegal pulses once, no regwrite/memwrite/pcwrite. FETCH follows. FETCH with mem_ready low for 3 cycles keeps irwrite=0 until the ready cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Constants shared by the multicycle MIPS control unit and its datapath:
//   opcode/funct values, the controller state encoding, and the encodings of
//   the aluop, alusrcb and pcsource selects.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // funct (IR[5:0]) selecting jr within R-type
  localparam logic [5:0] FUNCT_JR = 6'd8;

  // Controller states
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_e;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequences the shared multicycle MIPS datapath one instruction at a time.
//   Ports:
//     clk, reset_n          rising-edge clock, asynchronous active-low reset
//     opcode, funct         instruction fields from IR
//     mem_ready             memory finishes the current access this cycle
//     pcwrite, pcwritecond, branch_ne, pcsource   PC update control
//     iord, memread, memwrite, irwrite            memory / IR control
//     memtoreg, regdst, regwrite                  register file control
//     alusrca, alusrcb, aluop                     ALU operand/operation
//     instr_done            pulse in the last cycle of every instruction
//     illegal               pulse when an undecodable opcode is trapped
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       branch_ne,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:            state_d = (funct == FUNCT_JR) ? S_JR : S_REXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_TRAP;
        endcase
      end
      // Only lw/sw reach MEMADR, so anything but lw is a store.
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR, S_TRAP:
                state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 and IR load happen only in the cycle memory delivers the word,
        // so a stalled fetch can repeat without advancing the PC.
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;  // speculative branch target into ALUOut
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
        branch_ne   = (opcode == OP_BNE);
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_JR: begin
        pcwrite    = 1'b1;
        pcsource   = PCSRC_REGA;
        instr_done = 1'b1;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Builds, per instruction, the expected cycle-by-cycle control word from the
//   instruction class and memory wait counts, then replays it against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, instr_done, illegal;
  logic [1:0] alusrcb, aluop, pcsource;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .branch_ne(branch_ne), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One cycle of the plan: what to drive and the full control word expected.
  typedef struct {
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [19:0] exp;
    string       tag;
  } step_t;

  step_t plan[$];

  // Control word layout:
  // {pcwrite,pcwritecond,branch_ne,iord,memread,memwrite,irwrite,memtoreg,
  //  regdst,regwrite,alusrca,alusrcb[1:0],aluop[1:0],pcsource[1:0],instr_done,illegal}
  function automatic logic [19:0] mk(
    input logic pcw, input logic pcwc, input logic bne, input logic io,
    input logic mr, input logic mw, input logic irw, input logic m2r,
    input logic rd, input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] psrc, input logic done,
    input logic ill);
    return {pcw, pcwc, bne, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  function automatic logic [19:0] observed();
    return {pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
            memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
            instr_done, illegal};
  endfunction

  task automatic chk(input logic [19:0] exp, input string tag);
    logic [19:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic [19:0] e, input string t);
    step_t s;
    s.rdy = r; s.op = op; s.fn = fn; s.exp = e; s.tag = t;
    plan.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected behaviour of one instruction, derived from its class.
  // fw = fetch wait cycles, mwait = data memory wait cycles.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mwait, input string name);
    for (int i = 0; i < fw; i++)
      push(1'b0, op, fn, mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), {name, "_fetch_wait"});
    push(1'b1, op, fn, mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0), {name, "_fetch"});
    push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0), {name, "_decode"});
    if (op == 6'd35 || op == 6'd43) begin
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), {name, "_addr"});
      for (int i = 0; i <= mwait; i++) begin
        logic r;
        r = (i == mwait);
        if (op == 6'd35)
          push(r, op, fn, mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), {name, "_memrd"});
        else
          push(r, op, fn, mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,r,0), {name, "_memwr"});
      end
      if (op == 6'd35)
        push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0), {name, "_memwb"});
    end else if (op == 6'd0 && fn == 6'd8) begin
      push(rnd_bit(), op, fn, mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,1,0), {name, "_jr"});
    end else if (op == 6'd0) begin
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), {name, "_rexec"});
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0), {name, "_rwb"});
    end else if (op == 6'd8 || op == 6'd10) begin
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,(op == 6'd10) ? 2'b11 : 2'b00,2'b00,0,0), {name, "_iexec"});
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0), {name, "_iwb"});
    end else if (op == 6'd4 || op == 6'd5) begin
      push(rnd_bit(), op, fn, mk(0,1,(op == 6'd5),0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0), {name, "_branch"});
    end else if (op == 6'd2) begin
      push(rnd_bit(), op, fn, mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0), {name, "_jump"});
    end else begin
      push(rnd_bit(), op, fn, mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1), {name, "_trap"});
    end
  endtask

  // Replays the plan: drive at the falling edge, check 1ns later.
  task automatic run_plan();
    while (plan.size() > 0) begin
      step_t s;
      s = plan.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      opcode    = s.op;
      funct     = s.fn;
      #1;
      chk(s.exp, s.tag);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ready = rnd_bit();
      #1;
      chk(20'h0, "reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk(20'h0, "reset_state");
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd5 ||
           op == 6'd8 || op == 6'd10 || op == 6'd35 || op == 6'd43;
  endfunction

  initial begin
    #1;
    chk(20'h0, "reset_async");
    do_reset();

    // Directed instructions
    plan_instr(6'd0,  6'd32, 0, 0, "add");
    plan_instr(6'd35, 6'd0,  0, 2, "lw_stall2");
    plan_instr(6'd5,  6'd0,  0, 0, "bne");
    plan_instr(6'd4,  6'd0,  0, 0, "beq");
    plan_instr(6'd10, 6'd0,  0, 0, "slti");
    plan_instr(6'd8,  6'd0,  0, 0, "addi");
    plan_instr(6'd2,  6'd0,  0, 0, "j");
    plan_instr(6'd0,  6'd8,  0, 0, "jr");
    plan_instr(6'd63, 6'd0,  0, 0, "illegal63");
    plan_instr(6'd0,  6'd34, 3, 0, "sub_fetch3");
    plan_instr(6'd43, 6'd0,  1, 2, "sw_stall");
    run_plan();

    // Reset in the middle of a stalled store
    plan_instr(6'd43, 6'd0, 0, 5, "sw_abort");
    while (plan.size() > 4) void'(plan.pop_back());
    run_plan();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    assert (memwrite === 1'b0) else begin
      failures++;
      $error("FAIL reset_memwrite_drop observed=%b expected=0", memwrite);
    end
    chk(20'h0, "reset_midwrite");
    do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int k;
      k  = $urandom_range(0, 8);
      fn = 6'($urandom_range(0, 63));
      case (k)
        0: op = 6'd0;
        1: op = 6'd2;
        2: op = 6'd4;
        3: op = 6'd5;
        4: op = 6'd8;
        5: op = 6'd10;
        6: op = 6'd35;
        7: op = 6'd43;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      if (op == 6'd0 && $urandom_range(0, 3) == 0) fn = 6'd8;
      plan_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
    run_plan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
